// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised serial input, mid-bit sampling,
// one-cycle byte strobe and frame-error strobe.
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] UART_RX_Data_Out,
  output logic       UART_RX_Ready_Out,
  output logic       frame_err,
  output logic       busy
);

  localparam int BAUD_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV) + 1;

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic          sync1_r;
  logic          rs_r;
  logic [CW-1:0] baud_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          sample_bit_s;
  logic          load_byte_s;
  logic          frame_err_s;
  logic          restart_cnt_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      rs_r    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rs_r    <= sync1_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and single-cycle event flags.
  always_comb begin
    state_next_s = state_r;
    sample_bit_s = 1'b0;
    load_byte_s  = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rs_r) state_next_s = ST_START;
        else       state_next_s = ST_IDLE;
      end
      ST_START: begin
        if (baud_cnt_r == HALF_M1) begin
          if (rs_r) state_next_s = ST_IDLE;
          else      state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_cnt_r == LAST_CNT) begin
          sample_bit_s = 1'b1;
          if (bit_cnt_r == 3'd7) state_next_s = ST_STOP;
          else                   state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (baud_cnt_r == LAST_CNT) begin
          if (rs_r) begin
            load_byte_s  = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            frame_err_s  = 1'b1;
            state_next_s = ST_BREAK;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rs_r) state_next_s = ST_IDLE;
        else      state_next_s = ST_BREAK;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Each data sample also restarts the bit timer so DATA stays in-state.
  assign restart_cnt_s = (state_next_s != state_r) || sample_bit_s;

  // Baud timer and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
    end else begin
      if (restart_cnt_s) baud_cnt_r <= '0;
      else               baud_cnt_r <= baud_cnt_r + CNT_ONE;
      if (sample_bit_s)            bit_cnt_r <= bit_cnt_r + 3'd1;
      else if (state_r != ST_DATA) bit_cnt_r <= 3'd0;
      else                         bit_cnt_r <= bit_cnt_r;
    end
  end

  // Shift register (LSB arrives first) and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r           <= 8'h00;
      UART_RX_Data_Out  <= 8'h00;
      UART_RX_Ready_Out <= 1'b0;
      frame_err         <= 1'b0;
      busy              <= 1'b0;
    end else begin
      if (sample_bit_s) shift_r <= {rs_r, shift_r[7:1]};
      else              shift_r <= shift_r;
      if (load_byte_s) UART_RX_Data_Out <= shift_r;
      else             UART_RX_Data_Out <= UART_RX_Data_Out;
      UART_RX_Ready_Out <= load_byte_s;
      frame_err         <= frame_err_s;
      busy              <= (state_next_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=10: single frame, back-to-back,
// glitch, break, mid-frame reset and a full 0x00..0xFF transmitter loopback.
`timescale 1ns/1ps

module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       ready;
  logic       frame_err;
  logic       busy;

  int checks;
  int errors;
  int cyc;
  int rdy_t[$];
  logic [7:0] rdy_b[$];
  int fe_t[$];

  uart_rx #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx                (rx),
    .UART_RX_Data_Out  (data_out),
    .UART_RX_Ready_Out (ready),
    .frame_err         (frame_err),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder: each high sample is one cycle of strobe.
  always @(negedge clk) begin
    if (ready) begin
      rdy_t.push_back(cyc);
      rdy_b.push_back(data_out);
    end
    if (frame_err) fe_t.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remote transmitter: 10 clk per bit, called and returning on a negedge.
  task automatic send(input logic [7:0] b, input logic stop_bit, output int t_fall);
    rx = 1'b0;
    t_fall = cyc;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop_bit;
    repeat (10) @(negedge clk);
  endtask

  int t0, t1, t2, base;
  logic [7:0] c3;

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rx     = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, data_out}, 32'h00);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame 0xA5
    send(8'hA5, 1'b1, t0);
    chk("a5_count", rdy_b.size(), 32'd1);
    chk("a5_time", rdy_t[0], t0 + 98);
    chk("a5_byte", {24'd0, rdy_b[0]}, 32'hA5);
    chk("a5_data", {24'd0, data_out}, 32'hA5);
    chk("a5_ferr", fe_t.size(), 32'd0);
    chk("a5_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    // Back-to-back 0x00, 0xFF, 0x3C
    send(8'h00, 1'b1, t0);
    send(8'hFF, 1'b1, t1);
    send(8'h3C, 1'b1, t2);
    chk("b2b_count", rdy_b.size(), 32'd4);
    chk("b2b_byte0", {24'd0, rdy_b[1]}, 32'h00);
    chk("b2b_byte1", {24'd0, rdy_b[2]}, 32'hFF);
    chk("b2b_byte2", {24'd0, rdy_b[3]}, 32'h3C);
    chk("b2b_time0", rdy_t[1], t0 + 98);
    chk("b2b_gap1", rdy_t[2] - rdy_t[1], 32'd100);
    chk("b2b_gap2", rdy_t[3] - rdy_t[2], 32'd100);
    chk("b2b_data", {24'd0, data_out}, 32'h3C);
    repeat (5) @(negedge clk);

    // 3-clk glitch on idle line
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("glitch_nostrobe", rdy_b.size(), 32'd4);

    // 0x55 with stop bit 0, line held low 50 clk from stop-bit start
    send(8'h55, 1'b0, t0);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    chk("brk_ferr_count", fe_t.size(), 32'd1);
    chk("brk_ferr_time", fe_t[0], t0 + 98);
    chk("brk_nostrobe", rdy_b.size(), 32'd4);
    chk("brk_data_kept", {24'd0, data_out}, 32'h3C);
    repeat (20) @(negedge clk);
    chk("brk_busy", {31'd0, busy}, 32'd0);
    send(8'h81, 1'b1, t0);
    chk("post_brk_count", rdy_b.size(), 32'd5);
    chk("post_brk_byte", {24'd0, rdy_b[4]}, 32'h81);
    chk("post_brk_ferr", fe_t.size(), 32'd1);
    repeat (5) @(negedge clk);

    // Reset in the middle of bit 4 of 0xC3
    c3 = 8'hC3;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      repeat (10) @(negedge clk);
    end
    rx = c3[4];
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_data", {24'd0, data_out}, 32'h00);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("rst_nostrobe", rdy_b.size(), 32'd5);
    send(8'h12, 1'b1, t0);
    chk("post_rst_count", rdy_b.size(), 32'd6);
    chk("post_rst_byte", {24'd0, rdy_b[5]}, 32'h12);
    chk("post_rst_time", rdy_t[5], t0 + 98);
    repeat (5) @(negedge clk);

    // Loopback of every byte value
    base = rdy_b.size();
    for (int b = 0; b < 256; b++) begin
      send(8'(b), 1'b1, t0);
    end
    chk("loop_count", rdy_b.size(), base + 256);
    for (int i = 0; i < 256; i++) begin
      chk("loop_byte", {24'd0, rdy_b[base + i]}, i);
    end
    chk("loop_ferr", fe_t.size(), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
